// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined WIDTH-bit adder/subtractor with ALU flags.
// The operation is cut into STAGES carry-chained segments of SEG bits. Each
// segment is a small carry-lookahead add. A register sits after every segment.
// A single advance signal (adv) moves the whole pipeline forward together.
// Upper operand bits travel alongside the partial sum until their segment is added.
module pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SUB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             Z,
    output logic             N
);

    localparam int SEG = WIDTH / STAGES;
    // Operand-forwarding registers exist only between segments.
    localparam int NF  = (STAGES > 1) ? STAGES - 1 : 1;

    logic [STAGES-1:0]            vld_pipe;
    logic [STAGES-1:0]            vin;
    logic [STAGES-1:0][WIDTH-1:0] s_q, s_d;
    logic [STAGES-1:0]            c_q, c_d;
    logic [NF-1:0][WIDTH-1:0]     fa_q, fa_d;
    logic [NF-1:0][WIDTH-1:0]     fb_q, fb_d;
    logic                         v_q, z_q, n_q;
    logic                         v_d, z_d, n_d;
    logic                         adv;

    // SEG-bit generate/propagate add.
    // The result is {carry into segment MSB, carry out, sum}.
    function automatic logic [SEG+1:0] cla_seg(input logic [SEG-1:0] x,
                                               input logic [SEG-1:0] y,
                                               input logic           ci);
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        logic [SEG:0]   c;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return {c[SEG-1], c[SEG], p ^ c[SEG-1:0]};
    endfunction

    // The pipeline moves only when the output slot is empty or is being drained.
    always_comb begin
        adv = ~vld_pipe[STAGES-1] | out_ready;
    end

    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES-1];
    assign S         = s_q[STAGES-1];
    assign Cout      = c_q[STAGES-1];
    assign V         = v_q;
    assign Z         = z_q;
    assign N         = n_q;

    // Per-segment datapath.
    // Stage 0 takes the raw operands. Stage k takes what stage k-1 registered.
    // Consumed operand segments are zeroed so they do not travel further.
    always_comb begin
        logic [WIDTH-1:0] cur_a;
        logic [WIDTH-1:0] cur_b;
        logic [WIDTH-1:0] cur_s;
        logic             cur_c;
        logic [SEG+1:0]   r;
        s_d   = '0;
        c_d   = '0;
        fa_d  = '0;
        fb_d  = '0;
        vin   = '0;
        v_d   = 1'b0;
        z_d   = 1'b0;
        n_d   = 1'b0;
        cur_a = '0;
        cur_b = '0;
        cur_s = '0;
        cur_c = 1'b0;
        r     = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                cur_a  = A;
                cur_b  = SUB ? ~B : B;
                cur_s  = '0;
                cur_c  = SUB;
                vin[0] = in_valid;
            end else begin
                cur_a  = fa_q[k-1];
                cur_b  = fb_q[k-1];
                cur_s  = s_q[k-1];
                cur_c  = c_q[k-1];
                vin[k] = vld_pipe[k-1];
            end
            r                    = cla_seg(cur_a[k*SEG +: SEG], cur_b[k*SEG +: SEG], cur_c);
            s_d[k]               = cur_s;
            s_d[k][k*SEG +: SEG] = r[SEG-1:0];
            c_d[k]               = r[SEG];
            if (k < STAGES - 1) begin
                fa_d[k]               = cur_a;
                fa_d[k][k*SEG +: SEG] = '0;
                fb_d[k]               = cur_b;
                fb_d[k][k*SEG +: SEG] = '0;
            end else begin
                // The last segment holds the MSB. Overflow is carry-in XOR carry-out there.
                v_d = r[SEG+1] ^ r[SEG];
                z_d = ~|s_d[k];
                n_d = s_d[k][WIDTH-1];
            end
        end
    end

    // Stage registers.
    // Valid bits shift on every advance. Data loads only with a valid op.
    // This keeps the outputs steady while bubbles pass through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            s_q      <= '0;
            c_q      <= '0;
            fa_q     <= '0;
            fb_q     <= '0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
        end else if (adv) begin
            vld_pipe <= vin;
            for (int k = 0; k < STAGES; k++) begin
                if (vin[k]) begin
                    s_q[k] <= s_d[k];
                    c_q[k] <= c_d[k];
                end
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                if (vin[k]) begin
                    fa_q[k] <= fa_d[k];
                    fb_q[k] <= fb_d[k];
                end
            end
            if (vin[STAGES-1]) begin
                v_q <= v_d;
                z_q <= z_d;
                n_q <= n_d;
            end
        end
    end

endmodule

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
- Parametrised, pipelined adder/subtractor for the ALU datapath. Next generation of the 32-bit single-cycle CLA add/sub.
- Splits a WIDTH-bit operation into STAGES carry-chained segments with a register between segments. Adds a valid/ready handshake, global stall, and ALU flags (C, V, Z, N).
- Sits between the issue/operand stage and ALU writeback, so wider or faster-clocked cores can close timing.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of STAGES.
- STAGES, 2, number of pipeline segments (1..8); segment width SEG = WIDTH/STAGES.

Ports:
- clk  input  1  clock; all state rises on the posedge.
- rst  input  1  reset; asynchronous and active-high.
- in_valid  input  1  operands valid this cycle.
- in_ready  output  1  block can accept operands this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- SUB  input  1  1 = A-B (B inverted, carry-in 1); 0 = A+B (carry-in 0).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- S  output  WIDTH  sum/difference.
- Cout  output  1  carry out of MSB. For subtract, 1 means no borrow.
- V  output  1  signed overflow.
- Z  output  1  S == 0.
- N  output  1  S[WIDTH-1].

Behaviour:
- Reset (async, rst=1): all stage valid bits cleared; out_valid=0. S, Cout, V, Z, N=0. Partial results and carries cleared. Reset mid-operation discards all in-flight operations; no output is produced for them after rst deasserts.
- Stall: adv = ~out_valid | out_ready. in_ready = adv (combinational).
  - When adv=0, every pipeline register holds, including out_valid and all outputs.
  - When adv=1, all stages shift one position.
- Acceptance: an operation enters stage 0 on a posedge where in_valid & in_ready. An in_valid without in_ready is not captured; the source must hold its operands.
- Stage k (0..STAGES-1):
  - Adds segment k of A and ~B/B, using the carry from stage k-1 (stage 0 uses SUB).
  - Operand bits of segments above k are carried forward in the stage registers. Completed lower result segments are also carried forward.
  - Each segment is internally a SEG-bit carry-lookahead add (generate/propagate).
- Latency: exactly STAGES cycles from acceptance to out_valid=1 with no stall. Throughput: one operation per cycle while out_ready=1.
- Flags, computed in the final stage from the full WIDTH-bit result:
  - Cout = carry out of bit WIDTH-1.
  - V = carry into MSB XOR carry out of MSB.
  - Z = ~|S.
  - N = S[WIDTH-1].
- Bubbles: stage valid bits propagate with data. Bubbles move forward when adv=1, so a stalled output plus upstream bubbles compresses only on adv.
- Simultaneous events:
  - Output consumed and new input accepted in the same cycle is legal and loses no data.
  - rst overrides everything.
- Outputs S and the flags are registered and meaningful only while out_valid=1. They hold their last value while out_valid=0.
- STAGES=1: a single registered WIDTH-bit CLA add/sub with a 1-cycle latency.
- Wrap-around: add and subtract are modulo 2^WIDTH. Overflow is reported only through Cout and V; S is never saturated.

Test Plan:
- WIDTH=32, STAGES=2, SUB=0, A=0x7FFFFFFF, B=0x00000001, out_ready=1 → 2 cycles later out_valid=1, S=0x80000000, Cout=0, V=1, N=1, Z=0.
- SUB=1, A=5, B=5 → S=0, Z=1, Cout=1, V=0, N=0. Then SUB=1, A=3, B=5 → S=0xFFFFFFFE, Cout=0, N=1.
- Back-to-back stream of 8 random ops with out_ready=1 → 8 consecutive out_valid cycles, each matching a reference model, in order, with 2-cycle latency.
- out_ready=0 held for 4 cycles while in_valid=1 → in_ready drops once the output is full. No op is lost or duplicated, and the held S value stays stable. On release the stream resumes in order.
- rst pulsed asynchronously (mid-cycle) with 2 ops in flight → out_valid=0 immediately. After deassert, no stale result appears; a new op completes in STAGES cycles.
- WIDTH=64, STAGES=4, SUB=0, A=0xFFFFFFFFFFFFFFFF, B=1 → carry ripples across all four 16-bit segments. S=0, Cout=1, Z=1, with a 4-cycle latency.
